bmem_responder: RTL and testbench

//  Memory-side endpoint of the bmem burst interface driven by the core's cache/adapter path.

---
 rtl/bmem_responder.sv | 158 +++++++++++++++
 tb/tb_bmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bmem_responder
// Description : Memory-side endpoint of the bmem burst interface; stores lines
//               in a 64-bit word array and returns 4-beat read bursts in order.
// Revision    : 1.0 - initial release
// ============================================================================
module bmem_responder #(
    parameter int LATENCY   = 8,
    parameter int QDEPTH    = 4,
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid
);

    localparam int c_IDX_W  = $clog2(MEM_WORDS);
    localparam int c_LINE_W = c_IDX_W - 2;
    localparam int c_PTR_W  = $clog2(QDEPTH);
    localparam int c_CNT_W  = $clog2(LATENCY) + 1;

    logic [63:0]          r_mem   [MEM_WORDS];
    logic [255:0]         r_qdata [QDEPTH];
    logic [26:0]          r_qline [QDEPTH];
    logic [c_CNT_W-1:0]   r_qcnt  [QDEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [1:0]           r_wbeat;
    logic [c_LINE_W-1:0]  r_wline;
    logic [1:0]           r_rbeat;
    logic                 r_rvalid;
    logic [31:0]          r_raddr;
    logic [63:0]          r_rdata;

    logic [c_LINE_W-1:0]  w_line;
    logic                 w_full;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_wr_accept;
    logic                 w_pop;
    logic [255:0]         w_snap;
    logic                 w_continue;
    logic                 w_start;
    logic                 w_sel_valid;
    logic [c_PTR_W-1:0]   w_sel;
    logic [c_PTR_W-1:0]   w_idx;
    logic [1:0]           w_next_beat;
    logic                 w_unused_addr;

    assign w_line        = bmem_addr[c_IDX_W+2:5];
    assign w_unused_addr = ^bmem_addr[4:0];

    // Beat 3 on the output frees the head slot in this very cycle.
    assign w_pop       = r_rvalid && (r_rbeat == 2'd3);
    assign w_full      = (r_count == (c_PTR_W+1)'(QDEPTH));
    assign w_ready     = rst && (!w_full || w_pop) && (r_wbeat == 2'd0);
    assign w_push      = w_ready && bmem_read;
    assign w_wr_accept = w_ready && bmem_write && !bmem_read;

    assign bmem_ready  = w_ready;
    assign bmem_rvalid = r_rvalid;
    assign bmem_raddr  = r_raddr;
    assign bmem_rdata  = r_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap
            assign w_snap[64*gi +: 64] = r_mem[{w_line, 2'(gi)}];
        end
    endgenerate

    // Outputs are registered, so the entry for next cycle's beat is chosen now:
    // a waiting entry starts when its countdown will read 0 next cycle.
    always_comb begin
        w_continue  = r_rvalid && (r_rbeat != 2'd3);
        w_sel       = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
        w_sel_valid = w_pop ? (r_count > (c_PTR_W+1)'(1))
                            : (r_count != (c_PTR_W+1)'(0));
        w_start     = !w_continue && w_sel_valid && (r_qcnt[w_sel] <= c_CNT_W'(1));
        w_idx       = w_continue ? r_rd_ptr : w_sel;
        w_next_beat = w_continue ? (r_rbeat + 2'd1) : 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wbeat  <= '0;
            r_wline  <= '0;
            r_rbeat  <= '0;
            r_rvalid <= 1'b0;
            r_raddr  <= '0;
            r_rdata  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_qcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (r_qcnt[i] != '0) begin
                    r_qcnt[i] <= r_qcnt[i] - 1'b1;
                end
            end
            if (w_push) begin
                r_qcnt[r_wr_ptr] <= c_CNT_W'(LATENCY - 1);
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};

            if (w_wr_accept) begin
                r_wbeat <= 2'd1;
                r_wline <= w_line;
            end else if (r_wbeat != 2'd0) begin
                r_wbeat <= r_wbeat + 2'd1;
            end

            if (w_continue || w_start) begin
                r_rvalid <= 1'b1;
                r_rbeat  <= w_next_beat;
                r_raddr  <= {r_qline[w_idx], 5'b0};
                r_rdata  <= r_qdata[w_idx][{w_next_beat, 6'b0} +: 64];
            end else begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qdata[r_wr_ptr] <= w_snap;
            r_qline[r_wr_ptr] <= bmem_addr[31:5];
        end
    end

    // Array is not reset; beats 1..3 store whatever wdata is present.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[{w_line, 2'd0}] <= bmem_wdata;
        end else if (r_wbeat != 2'd0) begin
            r_mem[{r_wline, r_wbeat}] <= bmem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmem_responder
// Description : Scoreboard bench for bmem_responder read/write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmem_responder;

    localparam int c_LATENCY   = 8;
    localparam int c_QDEPTH    = 4;
    localparam int c_MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bmem_addr = '0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = '0;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    bmem_responder #(
        .LATENCY   (c_LATENCY),
        .QDEPTH    (c_QDEPTH),
        .MEM_WORDS (c_MEM_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    beat_t       sb[$];
    int          last_end = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model [c_MEM_WORDS];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bmem_rvalid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", {63'd0, bmem_rvalid}, 64'd0);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check_eq("beat_cycle", 64'(cyc), 64'(b.cyc));
                check_eq("beat_raddr", 64'(bmem_raddr), 64'(b.addr));
                check_eq("beat_rdata", bmem_rdata, b.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bmem_ready && n < 200) begin
            step();
            n++;
        end
        if (!bmem_ready) check_eq("ready_timeout", {63'd0, bmem_ready}, 64'd1);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[14:3]);
    endfunction

    task automatic push_expect(input logic [31:0] addr, input int t);
        int          b0;
        logic [31:0] line;
        line = {addr[31:5], 5'b0};
        b0   = (t + c_LATENCY > last_end + 1) ? t + c_LATENCY : last_end + 1;
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            e.cyc  = b0 + i;
            e.addr = line;
            e.data = model[widx(line) + i];
            sb.push_back(e);
        end
        last_end = b0 + 3;
    endtask

    task automatic do_read(input logic [31:0] addr, input bit wr_too, output int t);
        wait_ready();
        bmem_addr  = addr;
        bmem_read  = 1'b1;
        bmem_write = wr_too;
        bmem_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        t = cyc;
        push_expect(addr, t);
        step();
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] d [4];
        logic [31:0] line;
        d    = '{d0, d1, d2, d3};
        line = {addr[31:5], 5'b0};
        wait_ready();
        bmem_addr  = addr;
        bmem_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bmem_wdata = d[i];
            model[widx(line) + i] = d[i];
            if (i > 0) begin
                check_eq("ready_in_wbeat", {63'd0, bmem_ready}, 64'd0);
                bmem_addr = $urandom;
                bmem_read = (i == 2);
            end
            step();
        end
        bmem_write = 1'b0;
        bmem_read  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          t0;
        logic [31:0] pre [6];
        logic [63:0] base;
        pre = '{32'h000, 32'h020, 32'h040, 32'h060, 32'h200, 32'h300};

        repeat (3) step();
        check_eq("rst_ready", {63'd0, bmem_ready}, 64'd0);
        check_eq("rst_rvalid", {63'd0, bmem_rvalid}, 64'd0);
        check_eq("rst_raddr", 64'(bmem_raddr), 64'd0);
        check_eq("rst_rdata", bmem_rdata, 64'd0);
        rst = 1'b1;
        #1;
        check_eq("ready_after_rst", {63'd0, bmem_ready}, 64'd1);
        step();

        // Test 1: preload and single read latency
        do_write(32'h100, 64'd11, 64'd22, 64'd33, 64'd44);
        for (int k = 0; k < 6; k++) begin
            base = {32'hC0DE_0000, pre[k]};
            do_write(pre[k], base, base + 64'd1, base + 64'd2, base + 64'd3);
        end
        do_read(32'h100, 1'b0, t);
        drain();

        // Test 2: fill the queue with back-to-back reads
        do_read(32'h000, 1'b0, t0);
        do_read(32'h020, 1'b0, t);
        do_read(32'h040, 1'b0, t);
        do_read(32'h060, 1'b0, t);
        check_eq("full_ready_low", {63'd0, bmem_ready}, 64'd0);
        wait_cycle(t0 + c_LATENCY + 2);
        check_eq("full_before_pop", {63'd0, bmem_ready}, 64'd0);
        wait_cycle(t0 + c_LATENCY + 3);
        check_eq("ready_at_beat3", {63'd0, bmem_ready}, 64'd1);
        drain();

        // Test 3: read snapshot versus later write
        do_read(32'h200, 1'b0, t);
        do_write(32'h200, 64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0001,
                 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003);
        drain();
        do_read(32'h200, 1'b0, t);
        drain();

        // Test 4: simultaneous read and write is a read only
        do_read(32'h300, 1'b1, t);
        check_eq("rw_ready_stays", {63'd0, bmem_ready}, 64'd1);
        drain();
        do_read(32'h300, 1'b0, t);
        drain();

        // Test 6: index aliasing
        do_write(32'h0000_8000, 64'h5151_0000_0000_0000, 64'h5151_0000_0000_0001,
                 64'h5151_0000_0000_0002, 64'h5151_0000_0000_0003);
        do_read(32'h0000_0000, 1'b0, t);
        drain();

        // Test 5: reset in the middle of a burst
        do_read(32'h100, 1'b0, t0);
        do_read(32'h200, 1'b0, t);
        do_read(32'h300, 1'b0, t);
        wait_cycle(t0 + c_LATENCY + 2);
        check_eq("beat2_valid", {63'd0, bmem_rvalid}, 64'd1);
        rst = 1'b0;
        #1;
        check_eq("rvalid_async_drop", {63'd0, bmem_rvalid}, 64'd0);
        sb.delete();
        last_end = 0;
        step();
        step();
        check_eq("midrst_ready", {63'd0, bmem_ready}, 64'd0);
        check_eq("midrst_raddr", 64'(bmem_raddr), 64'd0);
        rst = 1'b1;
        #1;
        check_eq("ready_after_midrst", {63'd0, bmem_ready}, 64'd1);
        repeat (20) step();
        do_read(32'h100, 1'b0, t);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
